idex_hazard_reg: RTL and testbench
==================================

# idex_hazard_reg

ID/EX pipeline register with load-use hazard detection for the pipelined MIPS core. Captures the register-file read data, immediate and decoded control from the decode stage each cycle and presents them to the execute stage. Detects load-use hazards against the instruction currently in EX, requests a one-cycle stall upstream and inserts a bubble. Handles branch flush, keeps destination-register selection local, and maintains saturating stall/flush event counters.

## Interface
- DW, 32, datapath width of register and immediate values
- CW, 16, width of the stall and flush event counters
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- ce  in  1  global clock enable; 0 freezes all state
- flush  in  1  branch/jump taken in EX; squash the instruction entering EX
- id_valid  in  1  decode stage holds a real instruction
- id_rs, id_rt, id_rd  in  5 each  source and destination register numbers
- id_uses_rt  in  1  instruction reads rt as a source (R-type, store, beq/bne)
- id_reg1, id_reg2  in  DW each  register-file read data for rs and rt
- id_imm  in  DW  sign/zero-extended immediate
- id_regdst, id_alusrc, id_memread, id_memwrite, id_memtoreg, id_regwrite  in  1 each  decoded control
- id_aluop  in  4  ALU operation select
- stall  out  1  combinational; hold PC and IF/ID this cycle
- ex_valid  out  1  EX holds a real instruction
- ex_rs, ex_rt, ex_wreg  out  5 each  source numbers and resolved write register
- ex_reg1, ex_reg2, ex_imm  out  DW each  registered operands
- ex_alusrc, ex_memread, ex_memwrite, ex_memtoreg, ex_regwrite  out  1 each  registered control
- ex_aluop  out  4  registered ALU op
- stall_count, flush_count  out  CW each  saturating event counters

## Operation
- Hazard: hz = ex_valid & ex_memread & (ex_wreg != 0) & id_valid & ((ex_wreg == id_rs) | (id_uses_rt & ex_wreg == id_rt)).
- stall = hz & ~flush & ~rst. stall is independent of ce.
- Write register: wreg = id_regdst ? id_rd : id_rt. The captured regwrite is id_regwrite & id_valid & (wreg != 0); register 0 is never a write target.
- Update priority on each rising clk:
  1. rst: all ex_* = 0, counters = 0.
  2. else ce = 0: hold everything, including counters.
  3. else flush: bubble, flush_count += 1.
  4. else hz: bubble, stall_count += 1.
  5. else: load all ex_* from id_*; ex_valid = id_valid.
- Bubble: ex_valid and every control output = 0. Data and register-number fields = 0.
- Invalid loads (id_valid = 0) capture with all control outputs forced to 0.
- Counters stick at 2^CW−1 and never wrap.
- ex_memwrite and ex_memread are never both 1. If both id inputs are 1, memwrite is dropped.

## Timing
- Latency 1 cycle: id_* sampled at edge N appear on ex_* after edge N.
- stall is purely combinational from ex_* registers and id_* inputs, with no internal path back into itself.
- A load followed by a dependent instruction stalls exactly 1 cycle. After the bubble, ex_memread = 0, so hz clears and the held ID instruction loads on the next edge.
- Back-to-back loads where the second load uses the first's result: 1 stall. The second load then becomes the new hazard source for its own consumer.
- flush and hz in the same cycle: flush wins, stall = 0, and only flush_count increments.
- rst mid-stall: the next cycle has stall = 0 because ex_valid = 0.
- ce = 0 during hz: stall stays asserted and state is frozen; the bubble is inserted on the first edge with ce = 1.

## Test plan
- After reset: all ex_* = 0, stall = 0, counters = 0. Apply id_valid = 1, rs = 3, rt = 4, rd = 5, regdst = 1, regwrite = 1, reg1 = 0x11, reg2 = 0x22 -> one edge later ex_wreg = 5, ex_regwrite = 1, ex_reg1 = 0x11.
- lw $8 into EX, then add using rs = 8 in ID -> stall = 1 for exactly one cycle, then ex_valid = 0 for one cycle, then add appears in EX; stall_count = 1.
- lw $8 in EX, ID instruction has rt = 8 with id_uses_rt = 0 (addi target) -> stall = 0, no bubble.
- lw $0 in EX (ex_wreg = 0) followed by a consumer of $0 -> no stall. Separately, a load to rd = 0 with regwrite = 1 yields ex_regwrite = 0.
- Hazard and flush asserted together -> stall = 0, bubble inserted, flush_count = 1, stall_count unchanged.
- CW = 2: force 5 stalls -> stall_count saturates at 3. Hold ce = 0 across a hazard for 3 cycles -> outputs frozen, bubble on the first ce = 1 edge.

Source files
------------

// File: rtl/idex_hazard_reg.sv
// ID/EX pipeline register with load-use hazard detection, branch flush bubbles and saturating event counters.
// Latency 1 cycle; stall is combinational upstream backpressure; ce=0 freezes all state.
module idex_hazard_reg #(
  parameter int DW = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  input  logic          flush,
  input  logic          id_valid,
  input  logic [4:0]    id_rs,
  input  logic [4:0]    id_rt,
  input  logic [4:0]    id_rd,
  input  logic          id_uses_rt,
  input  logic [DW-1:0] id_reg1,
  input  logic [DW-1:0] id_reg2,
  input  logic [DW-1:0] id_imm,
  input  logic          id_regdst,
  input  logic          id_alusrc,
  input  logic          id_memread,
  input  logic          id_memwrite,
  input  logic          id_memtoreg,
  input  logic          id_regwrite,
  input  logic [3:0]    id_aluop,
  output logic          stall,
  output logic          ex_valid,
  output logic [4:0]    ex_rs,
  output logic [4:0]    ex_rt,
  output logic [4:0]    ex_wreg,
  output logic [DW-1:0] ex_reg1,
  output logic [DW-1:0] ex_reg2,
  output logic [DW-1:0] ex_imm,
  output logic          ex_alusrc,
  output logic          ex_memread,
  output logic          ex_memwrite,
  output logic          ex_memtoreg,
  output logic          ex_regwrite,
  output logic [3:0]    ex_aluop,
  output logic [CW-1:0] stall_count,
  output logic [CW-1:0] flush_count
);

  typedef struct packed {
    logic          valid;
    logic [4:0]    rs;
    logic [4:0]    rt;
    logic [4:0]    wreg;
    logic [DW-1:0] reg1;
    logic [DW-1:0] reg2;
    logic [DW-1:0] imm;
    logic          alusrc;
    logic          memread;
    logic          memwrite;
    logic          memtoreg;
    logic          regwrite;
    logic [3:0]    aluop;
  } ex_t;

  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  ex_t        ex_q;
  ex_t        ex_d;
  logic       hz;
  logic [4:0] wreg;

  assign wreg = id_regdst ? id_rd : id_rt;

  // Only the instruction already in EX can be a hazard source, so stall never feeds back on itself.
  always_comb begin
    hz = ex_q.valid & ex_q.memread & (ex_q.wreg != 5'd0) & id_valid &
         ((ex_q.wreg == id_rs) | (id_uses_rt & (ex_q.wreg == id_rt)));
  end

  assign stall = hz & ~flush & ~rst;

  always_comb begin
    ex_d          = '0;
    ex_d.valid    = id_valid;
    ex_d.rs       = id_rs;
    ex_d.rt       = id_rt;
    ex_d.wreg     = wreg;
    ex_d.reg1     = id_reg1;
    ex_d.reg2     = id_reg2;
    ex_d.imm      = id_imm;
    ex_d.alusrc   = id_valid & id_alusrc;
    ex_d.memread  = id_valid & id_memread;
    // A decode that asks for both read and write keeps the read.
    ex_d.memwrite = id_valid & id_memwrite & ~id_memread;
    ex_d.memtoreg = id_valid & id_memtoreg;
    ex_d.regwrite = id_valid & id_regwrite & (wreg != 5'd0);
    ex_d.aluop    = id_valid ? id_aluop : 4'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q        <= '0;
      stall_count <= '0;
      flush_count <= '0;
    end else if (ce) begin
      if (flush) begin
        ex_q <= '0;
        if (flush_count != CNT_MAX) flush_count <= flush_count + CNT_ONE;
      end else if (hz) begin
        ex_q <= '0;
        if (stall_count != CNT_MAX) stall_count <= stall_count + CNT_ONE;
      end else begin
        ex_q <= ex_d;
      end
    end
  end

  assign ex_valid    = ex_q.valid;
  assign ex_rs       = ex_q.rs;
  assign ex_rt       = ex_q.rt;
  assign ex_wreg     = ex_q.wreg;
  assign ex_reg1     = ex_q.reg1;
  assign ex_reg2     = ex_q.reg2;
  assign ex_imm      = ex_q.imm;
  assign ex_alusrc   = ex_q.alusrc;
  assign ex_memread  = ex_q.memread;
  assign ex_memwrite = ex_q.memwrite;
  assign ex_memtoreg = ex_q.memtoreg;
  assign ex_regwrite = ex_q.regwrite;
  assign ex_aluop    = ex_q.aluop;

endmodule

// File: tb/tb_idex_hazard_reg.sv
// Bench for idex_hazard_reg: directed test-plan sequences, then randomized traffic against a reference model.
module tb_idex_hazard_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, ce, flush, id_valid, id_uses_rt;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_reg1, id_reg2, id_imm;
  logic        id_regdst, id_alusrc, id_memread, id_memwrite, id_memtoreg, id_regwrite;
  logic [3:0]  id_aluop;

  logic        stall, ex_valid, ex_alusrc, ex_memread, ex_memwrite, ex_memtoreg, ex_regwrite;
  logic [4:0]  ex_rs, ex_rt, ex_wreg;
  logic [31:0] ex_reg1, ex_reg2, ex_imm;
  logic [3:0]  ex_aluop;
  logic [15:0] stall_count, flush_count;

  logic        s2_stall, s2_valid, s2_alusrc, s2_memread, s2_memwrite, s2_memtoreg, s2_regwrite;
  logic [4:0]  s2_rs, s2_rt, s2_wreg;
  logic [31:0] s2_reg1, s2_reg2, s2_imm;
  logic [3:0]  s2_aluop;
  logic [1:0]  s2_stall_count, s2_flush_count;

  idex_hazard_reg #(.DW(32), .CW(16)) dut (
    .clk(clk), .rst(rst), .ce(ce), .flush(flush), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_uses_rt(id_uses_rt),
    .id_reg1(id_reg1), .id_reg2(id_reg2), .id_imm(id_imm),
    .id_regdst(id_regdst), .id_alusrc(id_alusrc), .id_memread(id_memread),
    .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg), .id_regwrite(id_regwrite),
    .id_aluop(id_aluop), .stall(stall), .ex_valid(ex_valid),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_wreg(ex_wreg),
    .ex_reg1(ex_reg1), .ex_reg2(ex_reg2), .ex_imm(ex_imm),
    .ex_alusrc(ex_alusrc), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_memtoreg(ex_memtoreg), .ex_regwrite(ex_regwrite), .ex_aluop(ex_aluop),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  idex_hazard_reg #(.DW(32), .CW(2)) dut2 (
    .clk(clk), .rst(rst), .ce(ce), .flush(flush), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_uses_rt(id_uses_rt),
    .id_reg1(id_reg1), .id_reg2(id_reg2), .id_imm(id_imm),
    .id_regdst(id_regdst), .id_alusrc(id_alusrc), .id_memread(id_memread),
    .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg), .id_regwrite(id_regwrite),
    .id_aluop(id_aluop), .stall(s2_stall), .ex_valid(s2_valid),
    .ex_rs(s2_rs), .ex_rt(s2_rt), .ex_wreg(s2_wreg),
    .ex_reg1(s2_reg1), .ex_reg2(s2_reg2), .ex_imm(s2_imm),
    .ex_alusrc(s2_alusrc), .ex_memread(s2_memread), .ex_memwrite(s2_memwrite),
    .ex_memtoreg(s2_memtoreg), .ex_regwrite(s2_regwrite), .ex_aluop(s2_aluop),
    .stall_count(s2_stall_count), .flush_count(s2_flush_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  typedef struct {
    bit        valid;
    bit [4:0]  rs, rt, wreg;
    bit [31:0] reg1, reg2, imm;
    bit        alusrc, memread, memwrite, memtoreg, regwrite;
    bit [3:0]  aluop;
  } exs_t;

  exs_t m, n;
  int   sc, fc;

  function automatic bit model_hz(exs_t e);
    return e.valid && e.memread && e.wreg != 0 && id_valid &&
           (e.wreg == id_rs || (id_uses_rt && e.wreg == id_rt));
  endfunction

  function automatic int sat(int v, int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic idle_inputs();
    ce = 1; flush = 0; id_valid = 0; id_uses_rt = 0;
    id_rs = 0; id_rt = 0; id_rd = 0; id_reg1 = 0; id_reg2 = 0; id_imm = 0;
    id_regdst = 0; id_alusrc = 0; id_memread = 0; id_memwrite = 0;
    id_memtoreg = 0; id_regwrite = 0; id_aluop = 0;
  endtask

  task automatic compare_all();
    check("ex_valid", 64'(ex_valid), 64'(m.valid));
    check("ex_regs", {49'd0, ex_rs, ex_rt, ex_wreg}, {49'd0, m.rs, m.rt, m.wreg});
    check("ex_reg1", 64'(ex_reg1), 64'(m.reg1));
    check("ex_reg2", 64'(ex_reg2), 64'(m.reg2));
    check("ex_imm", 64'(ex_imm), 64'(m.imm));
    check("ex_ctl", {55'd0, ex_alusrc, ex_memread, ex_memwrite, ex_memtoreg, ex_regwrite, ex_aluop},
                    {55'd0, m.alusrc, m.memread, m.memwrite, m.memtoreg, m.regwrite, m.aluop});
    check("stall_count", 64'(stall_count), 64'(sat(sc, 65535)));
    check("flush_count", 64'(flush_count), 64'(sat(fc, 65535)));
    check("stall_count_cw2", 64'(s2_stall_count), 64'(sat(sc, 3)));
    check("flush_count_cw2", 64'(s2_flush_count), 64'(sat(fc, 3)));
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 64'(ex_valid), 64'd0);
    check("rst_ctl", {59'd0, ex_memread, ex_memwrite, ex_regwrite, ex_alusrc, ex_memtoreg}, 64'd0);
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_counts", {32'd0, stall_count, flush_count}, 64'd0);
    rst = 0;

    // R-type: rd selected as write register.
    id_valid = 1; id_rs = 3; id_rt = 4; id_rd = 5; id_regdst = 1; id_regwrite = 1;
    id_reg1 = 32'h11; id_reg2 = 32'h22;
    @(posedge clk); #1;
    check("rtype_wreg", 64'(ex_wreg), 64'd5);
    check("rtype_regwrite", 64'(ex_regwrite), 64'd1);
    check("rtype_reg1", 64'(ex_reg1), 64'h11);

    // lw $8 then a dependent add: one stall, one bubble, then the add.
    id_rs = 1; id_rt = 8; id_regdst = 0; id_memread = 1; id_memtoreg = 1; id_uses_rt = 0;
    @(posedge clk); #1;
    id_rs = 8; id_rt = 2; id_rd = 9; id_regdst = 1; id_memread = 0; id_memtoreg = 0; id_uses_rt = 1;
    #1;
    check("lu_stall", 64'(stall), 64'd1);
    @(posedge clk); #1;
    check("lu_bubble", 64'(ex_valid), 64'd0);
    check("lu_stall_clear", 64'(stall), 64'd0);
    check("lu_stall_count", 64'(stall_count), 64'd1);
    @(posedge clk); #1;
    check("lu_add_in_ex", {58'd0, ex_valid, ex_rs}, {58'd0, 1'b1, 5'd8});
    check("lu_add_wreg", 64'(ex_wreg), 64'd9);

    // Random phase: first cycle is a reset so the model starts from a known state.
    m = '{default: 0};
    sc = 0; fc = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst         = (cyc == 0) || ($urandom_range(0, 99) < 2);
      ce          = $urandom_range(0, 99) < 85;
      flush       = $urandom_range(0, 99) < 10;
      id_valid    = $urandom_range(0, 99) < 85;
      id_rs       = 5'($urandom_range(0, 3));
      id_rt       = 5'($urandom_range(0, 3));
      id_rd       = 5'($urandom_range(0, 3));
      id_uses_rt  = 1'($urandom);
      id_reg1     = $urandom;
      id_reg2     = $urandom;
      id_imm      = $urandom;
      id_regdst   = 1'($urandom);
      id_alusrc   = 1'($urandom);
      id_memread  = $urandom_range(0, 99) < 45;
      id_memwrite = $urandom_range(0, 99) < 30;
      id_memtoreg = 1'($urandom);
      id_regwrite = $urandom_range(0, 99) < 80;
      id_aluop    = 4'($urandom);
      #1;
      check("stall", 64'(stall), 64'(model_hz(m) && !flush && !rst));
      check("stall_cw2", 64'(s2_stall), 64'(model_hz(m) && !flush && !rst));

      n = m;
      if (rst) begin
        n = '{default: 0}; sc = 0; fc = 0;
      end else if (ce) begin
        if (flush) begin
          n = '{default: 0}; fc++;
        end else if (model_hz(m)) begin
          n = '{default: 0}; sc++;
        end else begin
          n.valid    = id_valid;
          n.rs       = id_rs;
          n.rt       = id_rt;
          n.wreg     = id_regdst ? id_rd : id_rt;
          n.reg1     = id_reg1;
          n.reg2     = id_reg2;
          n.imm      = id_imm;
          n.alusrc   = id_valid && id_alusrc;
          n.memread  = id_valid && id_memread;
          n.memwrite = id_valid && id_memwrite && !id_memread;
          n.memtoreg = id_valid && id_memtoreg;
          n.regwrite = id_valid && id_regwrite && n.wreg != 0;
          n.aluop    = id_valid ? id_aluop : 4'd0;
        end
      end
      @(posedge clk); #1;
      m = n;
      compare_all();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
